// File: rtl/duty_ramp.sv
// Ramps a registered PWM duty value one STEP per PWM period toward a debounced switch target.
// Optional feature macro DUTY_RAMP_DEBOUNCE_EN: when defined, TARGET passes through a stability counter.
module duty_ramp #(
  parameter int STEP      = 1,
  parameter int DB_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] SW,
  input  logic       E,
  output logic [6:0] DUTY,
  output logic       BUSY,
  output logic [6:0] TARGET
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;
  localparam logic [7:0] STEP8 = 8'(STEP);

  logic [6:0] sw_meta;
  logic       e_meta, e_sync, e_prev;
  logic       prime1, prime2, e_armed;
  logic       tick;

  // prime1/prime2 mark when e_sync holds a real sample; the detector only arms after
  // E has been seen low, so a level already high at reset release never ticks.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      e_meta  <= 1'b0;
      e_sync  <= 1'b0;
      e_prev  <= 1'b0;
      prime1  <= 1'b0;
      prime2  <= 1'b0;
      e_armed <= 1'b0;
    end else begin
      e_meta  <= E;
      e_sync  <= e_meta;
      e_prev  <= e_sync;
      prime1  <= 1'b1;
      prime2  <= prime1;
      e_armed <= e_armed | (prime2 & ~e_sync);
    end
  end

  assign tick = e_sync & ~e_prev & e_armed;

`ifdef DUTY_RAMP_DEBOUNCE_EN
  localparam logic [15:0] DB_MAX = 16'(DB_CYCLES - 1);

  logic [6:0]  sw_sync, sw_last;
  logic [15:0] db_cnt, db_cnt_nxt;
  logic        sw_diff, db_load;

  assign sw_diff = (sw_sync != sw_last);

  always_comb begin
    db_cnt_nxt = db_cnt;
    if (sw_diff)
      db_cnt_nxt = '0;
    else if (db_cnt != DB_MAX)
      db_cnt_nxt = db_cnt + 16'd1;
  end

  // Load only on the transition into the saturated count, so a stable input is not rewritten.
  assign db_load = (db_cnt_nxt == DB_MAX) && (sw_diff || (db_cnt != DB_MAX));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw_last <= '0;
      db_cnt  <= '0;
      TARGET  <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      sw_last <= sw_sync;
      db_cnt  <= db_cnt_nxt;
      if (db_load)
        TARGET <= sw_sync;
    end
  end
`else
  // TARGET doubles as the second synchronizer stage, giving a two-edge latency.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_meta <= '0;
      TARGET  <= '0;
    end else begin
      sw_meta <= SW;
      TARGET  <= sw_meta;
    end
  end
`endif

  logic [1:0] state, state_nxt;
  logic [7:0] up_sum;
  logic [6:0] up_val, dn_val, duty_nxt;

  always_comb begin
    state_nxt = IDLE;
    if (DUTY < TARGET)
      state_nxt = UP;
    else if (DUTY > TARGET)
      state_nxt = DOWN;
  end

  // Clamp arithmetic in 8 bits; the down path compares before subtracting to avoid underflow.
  always_comb begin
    up_sum   = {1'b0, DUTY} + STEP8;
    up_val   = (up_sum > {1'b0, TARGET}) ? TARGET : up_sum[6:0];
    dn_val   = ({1'b0, DUTY} < ({1'b0, TARGET} + STEP8)) ? TARGET : (DUTY - STEP8[6:0]);
    duty_nxt = DUTY;
    if (tick) begin
      case (state)
        UP:      if (DUTY < TARGET) duty_nxt = up_val;
        DOWN:    if (DUTY > TARGET) duty_nxt = dn_val;
        default: duty_nxt = DUTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DUTY  <= '0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt != IDLE);
      DUTY  <= duty_nxt;
    end
  end

endmodule
